// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - countdown inputs and scanned display outputs of seg_scan_driver
interface seg_scan_driver_if;
  logic [7:0] data;
  logic [7:0] data2;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  modport master (output data, output data2, input seg, input an, input busy);
  modport slave  (input data, input data2, output seg, output an, output busy);
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-dabble BCD conversion of two countdowns, scanned onto a 4-digit 7-seg display
module seg_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, CONV_M, CONV_C, COMMIT} state_t;

  state_t      state_q, state_d;
  logic        force_q, force_d;
  logic [7:0]  snap_m_q, snap_m_d, snap_c_q, snap_c_d;
  logic [11:0] acc_q, acc_d, acc_next;
  logic [2:0]  bit_q, bit_d;
  logic [11:0] tmp_m_q, tmp_m_d, tmp_c_q, tmp_c_d;
  logic [15:0] dig_q, dig_d;
  logic        busy_q, busy_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic        scan_en_q, scan_en_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  function automatic logic [11:0] dabble_step(input logic [11:0] a, input logic b);
    logic [11:0] t;
    t = a;
    for (int n = 0; n < 3; n++) begin
      if (t[n*4 +: 4] >= 4'd5) t[n*4 +: 4] = t[n*4 +: 4] + 4'd3;
    end
    return {t[10:0], b};
  endfunction

  // Out-of-range values become two dashes; a zero tens digit may be blanked.
  function automatic logic [7:0] digit_pair(input logic [11:0] bcd);
    logic [3:0] tens;
    if (bcd[11:8] != 4'd0) return 8'hEE;
    tens = bcd[7:4];
    if (LZ_BLANK && tens == 4'd0) tens = 4'hF;
    return {tens, bcd[3:0]};
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      4'hE:    return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    force_d   = force_q;
    snap_m_d  = snap_m_q;
    snap_c_d  = snap_c_q;
    acc_d     = acc_q;
    acc_next  = 12'd0;
    bit_d     = bit_q;
    tmp_m_d   = tmp_m_q;
    tmp_c_d   = tmp_c_q;
    dig_d     = dig_q;
    busy_d    = busy_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    scan_en_d = scan_en_q;
    seg_d     = seg_q;
    an_d      = an_q;

    case (state_q)
      IDLE: begin
        if (force_q || bus.data != snap_m_q || bus.data2 != snap_c_q) begin
          snap_m_d = bus.data;
          snap_c_d = bus.data2;
          force_d  = 1'b0;
          acc_d    = 12'd0;
          bit_d    = 3'd0;
          busy_d   = 1'b1;
          state_d  = CONV_M;
        end
      end
      CONV_M: begin
        acc_next = dabble_step(acc_q, snap_m_q[3'd7 - bit_q]);
        bit_d    = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          tmp_m_d = acc_next;
          acc_d   = 12'd0;
          state_d = CONV_C;
        end else begin
          acc_d = acc_next;
        end
      end
      CONV_C: begin
        acc_next = dabble_step(acc_q, snap_c_q[3'd7 - bit_q]);
        bit_d    = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          tmp_c_d = acc_next;
          acc_d   = 12'd0;
          state_d = COMMIT;
        end else begin
          acc_d = acc_next;
        end
      end
      default: begin
        dig_d   = {digit_pair(tmp_c_q), digit_pair(tmp_m_q)};
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Scan runs regardless of conversion; the display is dark until the first wrap.
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d   = '0;
      idx_d     = idx_q + 2'd1;
      scan_en_d = 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (scan_en_q) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(dig_q[{idx_q, 2'b00} +: 4]);
    end else begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      force_q   <= 1'b1;
      snap_m_q  <= 8'd0;
      snap_c_q  <= 8'd0;
      acc_q     <= 12'd0;
      bit_q     <= 3'd0;
      tmp_m_q   <= 12'd0;
      tmp_c_q   <= 12'd0;
      dig_q     <= 16'hFFFF;
      busy_q    <= 1'b0;
      presc_q   <= '0;
      idx_q     <= 2'd0;
      scan_en_q <= 1'b0;
      seg_q     <= 7'b1111111;
      an_q      <= 4'b1111;
    end else begin
      state_q   <= state_d;
      force_q   <= force_d;
      snap_m_q  <= snap_m_d;
      snap_c_q  <= snap_c_d;
      acc_q     <= acc_d;
      bit_q     <= bit_d;
      tmp_m_q   <= tmp_m_d;
      tmp_c_q   <= tmp_c_d;
      dig_q     <= dig_d;
      busy_q    <= busy_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      scan_en_q <= scan_en_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.busy = busy_q;
endmodule
